bus_reg_target: RTL and testbench
=================================

Name: bus_reg_target

Overview:
- Register-file responder on the CPU's shared tristate data bus; the target side of the bus that CPU-side tristate drivers initiate on.
- Decodes an address window, latches write data from the bus, and drives read data back onto the shared bus.
- Uses registered output enables, programmable wait states and a guaranteed one-cycle bus turnaround.
- Provides local registers to the peripheral logic behind it.

Parameters:
- BUS_ADDR_W, 8, bus address width.
- DATA_W, 8, bus data width.
- IDX_W, 2, register index width; the block holds 2**IDX_W registers.
- BASE, 8'hF0, window base; hit when bus_addr[BUS_ADDR_W-1:IDX_W] == BASE[BUS_ADDR_W-1:IDX_W].
- WAIT_CYC, 1, read wait states, range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_addr  in  BUS_ADDR_W  shared address bus.
- bus_data  inout  DATA_W  shared data bus; driven only while drive_en=1, else high-Z.
- bus_rd  in  1  read request, level, held by initiator until bus_rdy is seen.
- bus_wr  in  1  write request, level, held by initiator until bus_rdy is seen.
- bus_rdy  inout  1  shared ready line; driven 1 in DRIVE/WACK, 0 in WAIT, high-Z otherwise.
- regs  out  DATA_W*2**IDX_W  flattened register contents; reg i at bits [i*DATA_W +: DATA_W].
- wr_stb  out  1  one-cycle pulse when a register is written.
- wr_idx  out  IDX_W  index of the last written register.

Behaviour:
- Reset: clk is the only clock. rst_n=0 asynchronously forces:
  - state=IDLE, drive_en=0, so bus_data and bus_rdy go high-Z immediately, including mid-DRIVE;
  - all registers, wr_stb, wr_idx and the wait counter to 0.
- IDLE:
  - bus_rd=1 with hit and bus_wr=0: latch idx=bus_addr[IDX_W-1:0]. Go to WAIT with cnt=WAIT_CYC-1 if WAIT_CYC>0, else go to DRIVE.
  - bus_wr=1 with hit and bus_rd=0: on that edge write bus_data to regs[idx], pulse wr_stb for one cycle, set wr_idx=idx, go to WACK.
  - bus_rd=1 and bus_wr=1 together: protocol error; ignored, stay IDLE, nothing driven.
  - No hit: stay IDLE, nothing driven.
- WAIT: bus_rdy driven 0.
  - cnt==0: go to DRIVE.
  - Otherwise cnt decrements.
  - bus_rd drops: abort to IDLE; bus_data never driven.
- DRIVE:
  - On entry edge, snapshot out_q=regs[idx] and set drive_en=1.
  - bus_data=out_q and bus_rdy=1 from the first DRIVE cycle.
  - Stay while bus_rd=1; bus_rd=0 moves to TURN.
- TURN: drive_en=0 and everything high-Z for exactly one cycle, then IDLE. A new request arriving during TURN is not accepted until IDLE.
- WACK: bus_rdy=1 until bus_wr=0, then TURN.
- Read latency: request edge to bus_rdy=1 is WAIT_CYC+1 cycles.
- All enables come from flops; no combinational path from bus inputs to bus_data or bus_rdy.
- Read snapshot: data stays stable for the whole DRIVE phase even if the register changes.
- Address window: bus_addr is sampled only in IDLE; changes after acceptance are ignored.

Optional Feature:
- Macro: BUS_PARITY_EN.
- When defined:
  - Adds port bus_par, inout, 1, even parity of bus_data, and port par_err, out, 1, sticky error flag.
  - Reads: bus_par is driven with ^out_q under drive_en.
  - Writes: if ^bus_data != bus_par, the write is discarded, wr_stb stays 0, and par_err is set. The WACK handshake still completes.
  - par_err is cleared only by rst_n.
- When undefined: neither port exists and no check is performed.

Test Plan:
- Reset release, then write 8'hA5 to 8'hF2 -> wr_stb pulse with wr_idx=2; regs[23:16]=8'hA5; bus_rdy=1 until bus_wr drops; one high-Z cycle follows.
- Read 8'hF2 with WAIT_CYC=1 -> bus_rdy=0 for 1 cycle, then bus_data=8'hA5 and bus_rdy=1 on cycle 2; high-Z exactly 1 cycle after bus_rd drops.
- Read 8'h12 (miss) -> bus_data and bus_rdy remain Z throughout; regs unchanged.
- bus_rd and bus_wr both asserted to 8'hF0 -> no drive, no write, state stays IDLE.
- rst_n low during DRIVE -> bus_data Z in the same cycle with no clock edge needed; all regs=0.
- With BUS_PARITY_EN: write 8'h03 with bus_par=1 -> write dropped, par_err=1, bus_rdy handshake still completes.

Source files
------------

// File: rtl/bus_reg_target.sv
// bus_reg_target
//   Register-file target on a shared tristate CPU bus. Decodes an address
//   window, captures write data from the bus, and returns read data after a
//   programmable number of wait states. Every bus enable comes from flops, and
//   a one-cycle turnaround always follows each transfer.
//
// Ports
//   clk       in     system clock, rising edge
//   rst_n     in     asynchronous active-low reset
//   bus_addr  in     shared address bus
//   bus_data  inout  shared data bus, driven only while drive_en is set
//   bus_rd    in     read request level, held until bus_rdy is seen
//   bus_wr    in     write request level, held until bus_rdy is seen
//   bus_rdy   inout  shared ready: 0 in WAIT, 1 in DRIVE/WACK, else high-Z
//   regs      out    flattened registers, reg i at [i*DATA_W +: DATA_W]
//   wr_stb    out    one-cycle pulse on each register write
//   wr_idx    out    index of the last written register
//
// Optional build macro BUS_PARITY_EN adds:
//   bus_par   inout  even parity of bus_data (driven on reads)
//   par_err   out    sticky flag for writes with bad parity (cleared by reset)
module bus_reg_target #(
  parameter int                    BUS_ADDR_W = 8,
  parameter int                    DATA_W     = 8,
  parameter int                    IDX_W      = 2,
  parameter logic [BUS_ADDR_W-1:0] BASE       = 8'hF0,
  parameter int                    WAIT_CYC   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BUS_ADDR_W-1:0]        bus_addr,
  inout  wire  [DATA_W-1:0]            bus_data,
  input  logic                         bus_rd,
  input  logic                         bus_wr,
  inout  wire                          bus_rdy,
  output logic [DATA_W*(2**IDX_W)-1:0] regs,
  output logic                         wr_stb,
  output logic [IDX_W-1:0]             wr_idx
`ifdef BUS_PARITY_EN
  ,
  inout  wire                          bus_par,
  output logic                         par_err
`endif
);

  localparam int unsigned NREG     = 2**IDX_W;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DRIVE, ST_TURN, ST_WACK} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [NREG];
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  rd_idx;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] out_q;
  logic              drive_en;
  logic              rdy_oe;
  logic              rdy_val;
  logic              hit;
  logic              rd_req;
  logic              wr_req;
  logic              par_ok;

  assign hit    = (bus_addr[BUS_ADDR_W-1:IDX_W] == BASE[BUS_ADDR_W-1:IDX_W]);
  assign rd_req = hit && bus_rd && !bus_wr;
  assign wr_req = hit && bus_wr && !bus_rd;

  // With zero wait states DRIVE is entered straight from IDLE, before idx_q
  // holds the new index, so the snapshot takes the index from the bus.
  assign rd_idx = (state_q == ST_IDLE) ? bus_addr[IDX_W-1:0] : idx_q;

`ifdef BUS_PARITY_EN
  assign par_ok  = ((^bus_data) == bus_par);
  assign bus_par = drive_en ? (^out_q) : 1'bz;
`else
  assign par_ok  = 1'b1;
`endif

  assign bus_data = drive_en ? out_q : {DATA_W{1'bz}};
  assign bus_rdy  = rdy_oe ? rdy_val : 1'bz;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_req)      state_d = (WAIT_CYC > 0) ? ST_WAIT : ST_DRIVE;
        else if (wr_req) state_d = ST_WACK;
      end
      ST_WAIT: begin
        if (!bus_rd)            state_d = ST_IDLE;
        else if (cnt_q == '0)   state_d = ST_DRIVE;
      end
      ST_DRIVE: if (!bus_rd) state_d = ST_TURN;
      ST_TURN:  state_d = ST_IDLE;
      ST_WACK:  if (!bus_wr) state_d = ST_TURN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Ready-line outputs, decoded from the state flops only
  always_comb begin
    rdy_oe  = 1'b0;
    rdy_val = 1'b0;
    unique case (state_q)
      ST_WAIT:           rdy_oe = 1'b1;
      ST_DRIVE, ST_WACK: begin
        rdy_oe  = 1'b1;
        rdy_val = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: registers, read snapshot, wait counter, write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem[IDX_W'(i)] <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      drive_en <= 1'b0;
      wr_stb   <= 1'b0;
      wr_idx   <= '0;
    end else begin
      wr_stb   <= 1'b0;
      drive_en <= (state_d == ST_DRIVE);
      if (state_d == ST_DRIVE && state_q != ST_DRIVE) out_q <= mem[rd_idx];
      if (state_q == ST_IDLE) begin
        if (rd_req) begin
          idx_q <= bus_addr[IDX_W-1:0];
          cnt_q <= CNT_INIT;
        end else if (wr_req && par_ok) begin
          mem[bus_addr[IDX_W-1:0]] <= bus_data;
          wr_stb <= 1'b1;
          wr_idx <= bus_addr[IDX_W-1:0];
        end
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

`ifdef BUS_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       par_err <= 1'b0;
    else if (state_q == ST_IDLE && wr_req && !par_ok) par_err <= 1'b1;
  end
`endif

  always_comb begin
    regs = '0;
    for (int unsigned i = 0; i < NREG; i++) regs[i*DATA_W +: DATA_W] = mem[IDX_W'(i)];
  end

endmodule

// File: tb/tb_bus_reg_target.sv
// tb_bus_reg_target
//   Randomized scoreboard bench for bus_reg_target. The stimulus process acts
//   as the bus initiator and pushes the expected response of every accepted
//   transfer into a queue; a monitor pops and compares when the target shows
//   wr_stb (writes) or the first bus_rdy=1 of a read. Released bus lines are
//   pulled so high-Z is observable: bus_data reads 8'hFF, bus_rdy reads 0.
module tb_bus_reg_target;
  localparam int         BUS_ADDR_W = 8;
  localparam int         DATA_W     = 8;
  localparam int         IDX_W      = 2;
  localparam int         NREG       = 4;
  localparam int         WAIT_CYC   = 1;
  localparam logic [7:0] BASE       = 8'hF0;
  localparam logic [7:0] ZVAL       = 8'hFF;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic [7:0]  bus_addr = '0;
  logic        bus_rd   = 1'b0;
  logic        bus_wr   = 1'b0;
  wire  [7:0]  bus_data;
  wire         bus_rdy;
  logic [31:0] regs;
  logic        wr_stb;
  logic [1:0]  wr_idx;
  logic        wdrive   = 1'b0;
  logic [7:0]  wdata    = '0;

  assign bus_data = wdrive ? wdata : 8'bz;
  pullup   pu_data (bus_data);
  pulldown pd_rdy  (bus_rdy);

`ifdef BUS_PARITY_EN
  wire  bus_par;
  logic par_err;
  logic wpar = 1'b0;
  assign bus_par = wdrive ? wpar : 1'bz;
  pulldown pd_par (bus_par);
`endif

  bus_reg_target #(
    .BUS_ADDR_W(BUS_ADDR_W),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W),
    .BASE      (BASE),
    .WAIT_CYC  (WAIT_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus_addr(bus_addr),
    .bus_data(bus_data),
    .bus_rd  (bus_rd),
    .bus_wr  (bus_wr),
    .bus_rdy (bus_rdy),
    .regs    (regs),
    .wr_stb  (wr_stb),
    .wr_idx  (wr_idx)
`ifdef BUS_PARITY_EN
    ,
    .bus_par (bus_par),
    .par_err (par_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
  endfunction

  typedef struct {
    bit         is_wr;
    logic [1:0] idx;
    logic [7:0] data;
    int         issue;
    int         lat;
  } exp_t;

  exp_t       q[$];
  logic [7:0] model [NREG];
  bit         in_turn = 1'b0;

  function automatic bit is_hit(logic [7:0] addr);
    return addr[7:2] == BASE[7:2];
  endfunction

  // Monitor: compares whatever the target presents against the queue head
  initial begin : monitor
    bit   rd_got;
    exp_t e;
    rd_got = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus_rd) rd_got = 1'b0;
      if (wr_stb) begin
        if (q.size() == 0) check("wr_stb_unexpected", wr_stb, 1'b0);
        else begin
          e = q.pop_front();
          if (!e.is_wr) check("wr_stb_during_read", wr_stb, 1'b0);
          else begin
            check("wr_idx", wr_idx, e.idx);
            check("wr_data", regs[int'(e.idx)*DATA_W +: DATA_W], e.data);
            check("wr_lat", cyc - e.issue, e.lat);
          end
        end
      end
      if (bus_rd && bus_rdy && !rd_got) begin
        rd_got = 1'b1;
        if (q.size() == 0) check("rdy_unexpected", bus_rdy, 1'b0);
        else begin
          e = q.pop_front();
          if (e.is_wr) check("rdy_before_write", bus_rdy, 1'b0);
          else begin
            check("rd_data", bus_data, e.data);
            check("rd_lat", cyc - e.issue, e.lat);
`ifdef BUS_PARITY_EN
            check("rd_par", bus_par, ^e.data);
`endif
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input bit bad);
    int   extra;
    bit   got;
    exp_t e;
    extra = in_turn ? 1 : 0;
    in_turn = 1'b0;
    bus_addr = addr;
    wdata = data;
`ifdef BUS_PARITY_EN
    wpar = bad ? ~(^data) : ^data;
`endif
    wdrive = 1'b1;
    bus_wr = 1'b1;
    if (is_hit(addr)) begin
      if (!bad) begin
        model[addr[1:0]] = data;
        e = '{1'b1, addr[1:0], data, cyc, 1 + extra};
        q.push_back(e);
      end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = bus_rdy;
      end
      if (!got) check("wr_timeout", bus_rdy, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("wack_rdy", bus_rdy, 1'b1);
      end
      tick();
      bus_wr = 1'b0;
      wdrive = 1'b0;
      tick();
      check("wturn_rdy", bus_rdy, 1'b0);
      check("wturn_data", bus_data, ZVAL);
      in_turn = 1'b1;
    end else begin
      repeat (3) begin
        @(negedge clk);
        check("wmiss_rdy", bus_rdy, 1'b0);
      end
      tick();
      bus_wr = 1'b0;
      wdrive = 1'b0;
    end
  endtask

  task automatic do_read(input logic [7:0] addr);
    int         extra;
    bit         got;
    logic [7:0] expd;
    exp_t       e;
    extra = in_turn ? 1 : 0;
    in_turn = 1'b0;
    bus_addr = addr;
    bus_rd = 1'b1;
    if (is_hit(addr)) begin
      expd = model[addr[1:0]];
      e = '{1'b0, addr[1:0], expd, cyc, WAIT_CYC + 1 + extra};
      q.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = bus_rdy;
        if (!got) check("rd_wait_data_z", bus_data, ZVAL);
      end
      if (!got) check("rd_timeout", bus_rdy, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("drive_rdy", bus_rdy, 1'b1);
        check("drive_data", bus_data, expd);
      end
      tick();
      bus_rd = 1'b0;
      tick();
      check("rturn_rdy", bus_rdy, 1'b0);
      check("rturn_data", bus_data, ZVAL);
      in_turn = 1'b1;
    end else begin
      repeat (3) begin
        @(negedge clk);
        check("rmiss_rdy", bus_rdy, 1'b0);
        check("rmiss_data", bus_data, ZVAL);
      end
      tick();
      bus_rd = 1'b0;
    end
  endtask

  // Simultaneous read and write: a protocol error the target must ignore
  task automatic do_both(input logic [7:0] addr, input logic [7:0] data);
    in_turn = 1'b0;
    bus_addr = addr;
    wdata = data;
`ifdef BUS_PARITY_EN
    wpar = ^data;
`endif
    wdrive = 1'b1;
    bus_rd = 1'b1;
    bus_wr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("both_rdy", bus_rdy, 1'b0);
    end
    tick();
    bus_rd = 1'b0;
    bus_wr = 1'b0;
    wdrive = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] a;
    int         op;
    bit         got;
    exp_t       e;
    foreach (model[i]) model[i] = '0;

    #2 rst_n = 1'b0;
    #20;
    check("rst_regs", regs, '0);
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_wr_idx", wr_idx, '0);
    check("rst_rdy", bus_rdy, 1'b0);
    check("rst_data", bus_data, ZVAL);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_write(8'hF2, 8'hA5, 1'b0);
    check("regs_23_16", regs[23:16], 8'hA5);
    do_read(8'hF2);
    do_read(8'h12);
    do_both(8'hF0, 8'h5A);
    check("both_no_write", regs[7:0], model[0]);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        tick();
        in_turn = 1'b0;
      end
      a  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : {BASE[7:2], 2'($urandom)};
      op = $urandom_range(0, 9);
      if (op < 4)       do_write(a, 8'($urandom), 1'b0);
      else if (op < 8)  do_read(a);
      else if (op == 8) do_read({~BASE[7:6], 6'($urandom)});
      else              do_both(a, 8'($urandom));
    end
    for (int i = 0; i < NREG; i++) check("final_reg", regs[i*DATA_W +: DATA_W], model[i]);

    // Reset asserted mid-DRIVE must release the bus without a clock edge
    tick();
    in_turn = 1'b0;
    bus_addr = 8'hF1;
    bus_rd = 1'b1;
    e = '{1'b0, 2'd1, model[1], cyc, WAIT_CYC + 1};
    q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus_rdy;
    end
    if (!got) check("rst_rd_timeout", bus_rdy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", bus_data, ZVAL);
    check("mid_rst_rdy", bus_rdy, 1'b0);
    check("mid_rst_regs", regs, '0);
    bus_rd = 1'b0;
    foreach (model[i]) model[i] = '0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_read(8'hF1);
    do_write(8'hF3, 8'h3C, 1'b0);
    do_read(8'hF3);

`ifdef BUS_PARITY_EN
    check("par_err_clear", par_err, 1'b0);
    do_write(8'hF1, 8'h03, 1'b1);
    check("par_err_set", par_err, 1'b1);
    check("par_write_dropped", regs[15:8], model[1]);
`endif

    tick();
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
